// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] END_TICK = 4'(OVERSAMPLE - 1);
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus CPU-side holding register handshake
interface uart_rx_if;
  logic rx;
  logic ack;
  logic clr_err;
  logic [7:0] rdata;
  logic valid;
  logic frame_err;
  logic overrun;
  modport master(output rx, ack, clr_err, input rdata, valid, frame_err, overrun);
  modport slave(input rx, ack, clr_err, output rdata, valid, frame_err, overrun);
endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: divide-by-DIV prescaler producing one-cycle oversample ticks
module uart_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= (restart_i || cnt_q == W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
  assign tick_o = cnt_q == W'(DIV - 1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 16x-oversampled serial receiver with holding byte and sticky error flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave bus
);
  logic [1:0] sync_q;
  logic rxs;
  state_e state_q;
  logic [3:0] tcnt_q;
  logic [2:0] bcnt_q;
  logic [7:0] shift_q;
  logic [7:0] rdata_q;
  logic valid_q;
  logic ferr_q;
  logic ovr_q;
  logic tick;
  logic restart;
  logic stop_tick;
  logic deliver;
  logic ferr_set;
  assign rxs = sync_q[1];
  assign restart = state_q == IDLE && !rxs;
  assign stop_tick = state_q == STOP && tick && tcnt_q == END_TICK;
  assign deliver = stop_tick && rxs;
  assign ferr_set = stop_tick && !rxs;
  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .restart_i(restart),
    .tick_o(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      tcnt_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
      // an ack in the delivery cycle frees the holding register for the new byte
      if (deliver && (!valid_q || bus.ack)) begin
        rdata_q <= shift_q;
        valid_q <= 1'b1;
      end else if (bus.ack) valid_q <= 1'b0;
      ovr_q <= (deliver && valid_q && !bus.ack) ? 1'b1 : (bus.clr_err ? 1'b0 : ovr_q);
      ferr_q <= ferr_set ? 1'b1 : (bus.clr_err ? 1'b0 : ferr_q);
      case (state_q)
        IDLE: if (!rxs) begin
          state_q <= START;
          tcnt_q <= '0;
        end
        START: if (tick) begin
          if (tcnt_q == MID_TICK) begin
            state_q <= rxs ? IDLE : DATA;
            tcnt_q <= '0;
            bcnt_q <= '0;
          end else tcnt_q <= tcnt_q + 1'b1;
        end
        DATA: if (tick) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == END_TICK) begin
            shift_q <= {rxs, shift_q[7:1]};
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: if (tick) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == END_TICK) state_q <= rxs ? IDLE : BREAK;
        end
        BREAK: if (rxs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.rdata = rdata_q;
  assign bus.valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun = ovr_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, 16x oversampled from the system clock. It is the receive counterpart of the existing `uart` transmitter and sits beside it on the CPU data bus in the UART chip-select region. It presents one holding byte plus valid, framing-error and overrun flags to the CPU.

## Interface
- `DIV`, default 27: system clocks per oversample tick; bit period = 16·`DIV` clocks. 27 gives ≈115200 baud at 50 MHz.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `ack`  in  1  single-cycle pulse: CPU has consumed `rdata`; clears `valid`.
- `clr_err`  in  1  single-cycle pulse: clears `frame_err` and `overrun`.
- `rdata`  out  8  holding register, last accepted byte.
- `valid`  out  1  `rdata` holds an unconsumed byte.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a byte completed while `valid` was already set.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- Prescaler: counter 0..`DIV`-1 produces a one-cycle `tick`. It is reset to 0 on entry to START so that sampling is phase-aligned to the start edge.
- Per-bit tick counter `tcnt`, 4 bits, wraps 15→0. Bit counter `bcnt`, 3 bits.
- States:
  - IDLE: when `rxs`=0, go to START and clear `tcnt` and the prescaler.
  - START: on the tick where `tcnt`=7 (mid start bit), sample `rxs`. If it is 1 (glitch), return to IDLE. If it is 0, clear `tcnt` and `bcnt` and go to DATA.
  - DATA: on the tick where `tcnt`=15, shift `rxs` into bit 7 of the shift register (LSB-first arrival). After `bcnt`=7 is sampled, go to STOP.
  - STOP: on the tick where `tcnt`=15, sample `rxs`.
    - If 1: deliver the byte and go to IDLE.
    - If 0: set `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Delivery when `valid`=0: load `rdata` and set `valid`.
- Delivery when `valid`=1 and no `ack` in the same cycle: set `overrun`. `rdata` keeps the old byte and the new byte is dropped.
- `ack` coincident with delivery: load the new byte, `valid` stays 1, no overrun.
- `ack` while `valid`=0: no effect.
- `clr_err` coincident with a new error: the error wins and the flag stays 1.
- Reset values:
  - Outputs: `rdata`=0, `valid`=0, `frame_err`=0, `overrun`=0.
  - Internal: state IDLE; all counters and the shift register 0.

## Timing
- Synchronizer latency: 2 clocks from an `rx` edge to `rxs`.
- Start detection: START is entered 1 clock after `rxs` falls.
- Start-bit mid-sample: 8·`DIV` clocks after START entry.
- Data bit n (n=0..7): sampled (8+16(n+1))·`DIV` clocks after START entry.
- Stop bit: sampled 152·`DIV` clocks after START entry.
- `valid` / `frame_err` / `overrun` update 1 clock after the stop sample.
- Total from the `rx` falling edge to `valid`=1: 152·`DIV`+4 clocks, ±1.
- Tolerance: sampling at mid-bit tolerates about ±4% baud mismatch.
- Earliest next start: IDLE is re-entered in the same cycle the stop bit is accepted, so the next start edge can be detected immediately.
- Reset mid-frame: immediate return to IDLE with the partial byte discarded. Flags are cleared by reset only, not by a frame abort.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK);
  - the constant `OVERSAMPLE`=16;
  - the constants `MID_TICK`=7 and `END_TICK`=15.
- One sub-module, `uart_tick_gen`: parameterized by `DIV`, with a synchronous `restart` input and a single `tick` output. It is reusable by a future oversampled transmitter.
- The CPU-side read mux and address decode stay at top level and are not part of this block.

## Test plan
All scenarios use `DIV`=4, giving a bit period of 64 clocks.
1. Send 0xA5 at the nominal rate → `rdata`=0xA5 and `valid`=1 at 612±1 clocks after the falling edge. `ack` → `valid`=0 on the next clock.
2. Drive `rx` low for 20 clocks, then high → no state beyond START, `valid`=0, flags 0, FSM back in IDLE.
3. Send 0x3C with the stop bit low, then hold `rx` low for 200 clocks, then release and send 0x81 → `frame_err`=1 and 0x3C not delivered. Then `rdata`=0x81 and `valid`=1.
4. Send 0x11 then 0x22 back-to-back, no `ack` → `rdata`=0x11, `valid`=1, `overrun`=1. `clr_err` → `overrun`=0.
5. Send 0x55 and pulse `ack` exactly in the delivery cycle of a second byte 0x66 → `rdata`=0x66, `valid`=1, `overrun`=0.
6. Assert `reset` during data bit 4 of 0xF0, release, then send 0x0F → all outputs 0 during reset. After release, `rdata`=0x0F and `valid`=1 with no framing error.
